output_tile_scheduler: RTL
==========================

// Module: output_tile_scheduler
// PURPOSE
// - Sequences the row routers over the full output feature map: walks all i_o_size*i_o_size output coordinates
//   in batches of ROUTER_COUNT, one (x,y) per router lane, y inner (column) and x outer (row).
// - Sits between the layer controller (start/done) and the row-router datapath (valid/ready issue, done completion).
// PARAMETERS
// - ROUTER_COUNT  4  number of router lanes per batch (>=1)
// - ADDR_WIDTH    8  width of one coordinate and of i_o_size
// PORTS
// - i_clk           in   1                         clock
// - i_nrst          in   1                         reset, asynchronous, active-low
// - i_reg_clear     in   1                         synchronous clear, highest priority after reset
// - i_start         in   1                         start one layer; sampled only in IDLE
// - i_o_size        in   ADDR_WIDTH                output map side; captured on accepted i_start
// - o_x, o_y        out  ROUTER_COUNT x ADDR_WIDTH  per-lane row/column coordinate of current batch
// - o_lane_valid    out  ROUTER_COUNT              lane k carries a real coordinate
// - o_batch_valid   out  1                         batch presented to routers
// - i_batch_ready   in   1                         routers accept batch (handshake = valid & ready)
// - i_batch_done    in   1                         routers finished the accepted batch
// - o_busy          out  1                         high in every state except IDLE
// - o_done          out  1                         one-cycle pulse: layer complete
// - o_stall_cycles  out  32                        only with OTS_PERF_CNT_EN (see CONFIGURATION)
// BEHAVIOUR
// - Reset / i_reg_clear: state IDLE; o_x, o_y, o_lane_valid, o_batch_valid, o_busy, o_done all 0.
// - States: IDLE -> ISSUE -> WAIT_DONE -> (ISSUE | FINISH) -> IDLE.
// - IDLE: on i_start latch size S, remaining R = S*S (2*ADDR_WIDTH bits); base (x,y) = (0,0).
//   S==0 -> FINISH directly, no batch issued. Else -> ISSUE; o_batch_valid high the cycle after i_start.
// - ISSUE: o_batch_valid=1; o_x/o_y/o_lane_valid stable until handshake. Lane 0 = base; lane k = step(lane k-1):
//   y<S-1 -> y+1; else y=0 and x = (x<S-1) ? x+1 : 0. o_lane_valid[k] = (k < R).
//   Handshake -> R -= min(R, ROUTER_COUNT); base = step(lane ROUTER_COUNT-1); o_batch_valid drops next cycle; -> WAIT_DONE.
// - WAIT_DONE: i_batch_done sampled only here (ignored in other states). On done: R==0 -> FINISH, else -> ISSUE.
// - FINISH: o_done=1 for exactly one cycle, -> IDLE. i_start in FINISH is ignored.
// - Invalid lanes of a partial last batch still show stepped coordinates (don't-care to routers); mask is authoritative.
// - i_o_size changes after capture have no effect until next i_start.
// - i_reg_clear mid-layer: abort immediately to IDLE, no o_done pulse; simultaneous i_start ignored that cycle.
// - Back-to-back layers: i_start in IDLE the cycle after o_done is accepted.
// CONFIGURATION
// - Macro OTS_PERF_CNT_EN defined: o_stall_cycles counts cycles with o_batch_valid & ~i_batch_ready plus cycles
//   in WAIT_DONE without i_batch_done; cleared on accepted i_start, reset and i_reg_clear; saturates at 2^32-1.
// - Not defined: o_stall_cycles port absent, no counter logic.
// STRUCTURE
// - Shared package router_pkg: typedef coord_t (logic [ADDR_WIDTH-1:0]), enum ots_state_t {IDLE, ISSUE, WAIT_DONE, FINISH}.
// - Sub-module coord_stepper: combinational (x,y,S) -> next (x,y) with wrap; instantiated ROUTER_COUNT times
//   in a chain for lanes plus reused for next base.
// TESTING (ROUTER_COUNT=4, ADDR_WIDTH=8)
// - S=3, ready=1, done 2 cycles after each handshake -> batches {(0,0)(0,1)(0,2)(1,0)} mask 1111,
//   {(1,1)(1,2)(2,0)(2,1)} 1111, {(2,2),..} 0001; then single o_done pulse; R sequence 9,5,1,0.
// - S=2 -> one batch (0,0)(0,1)(1,0)(1,1) mask 1111, o_done after its done; S=1 -> (0,0) mask 0001.
// - S=0 -> no o_batch_valid ever; o_done pulses 2 cycles after i_start.
// - Hold i_batch_ready=0 for 5 cycles -> o_x/o_y/mask unchanged, valid held; stall count 5 (with OTS_PERF_CNT_EN).
// - i_batch_done asserted during ISSUE -> ignored; i_reg_clear in WAIT_DONE of batch 2 -> IDLE, no o_done, all outputs 0.
// - i_start held high through a whole layer -> second layer starts only after return to IDLE, base back at (0,0).

Source files
------------

// File: rtl/output_tile_scheduler_pkg.sv
// Shared router types: coordinate type, scheduler state encoding and default sizing.
// Optional stall counter in the scheduler is enabled with OTS_PERF_CNT_EN.
package router_pkg;

  localparam int OTS_ROUTER_COUNT = 4;
  localparam int OTS_ADDR_WIDTH   = 8;

  typedef logic [OTS_ADDR_WIDTH-1:0] coord_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2,
    FINISH    = 2'd3
  } ots_state_t;

endpackage

// File: rtl/output_tile_scheduler_if.sv
// Batch issue bus between the tile scheduler (master) and the row routers (slave).
// Handshake: a batch transfers on a cycle where o_batch_valid & i_batch_ready; the scheduler holds
// o_x/o_y/o_lane_valid stable until then, and i_batch_done later reports completion of that batch.
interface output_tile_scheduler_if #(
  parameter int ROUTER_COUNT = 4,
  parameter int ADDR_WIDTH   = 8
);
  logic [ROUTER_COUNT-1:0][ADDR_WIDTH-1:0] o_x;
  logic [ROUTER_COUNT-1:0][ADDR_WIDTH-1:0] o_y;
  logic [ROUTER_COUNT-1:0]                 o_lane_valid;
  logic                                    o_batch_valid;
  logic                                    i_batch_ready;
  logic                                    i_batch_done;

  modport master (
    output o_x, o_y, o_lane_valid, o_batch_valid,
    input  i_batch_ready, i_batch_done
  );

  modport slave (
    input  o_x, o_y, o_lane_valid, o_batch_valid,
    output i_batch_ready, i_batch_done
  );
endinterface

// File: rtl/output_tile_scheduler_coord_stepper.sv
// Advances one output coordinate in raster order (y inner, x outer), wrapping to (0,0) past the corner.
module coord_stepper #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic [ADDR_WIDTH-1:0] i_x,
  input  logic [ADDR_WIDTH-1:0] i_y,
  input  logic [ADDR_WIDTH-1:0] i_size,
  output logic [ADDR_WIDTH-1:0] o_x,
  output logic [ADDR_WIDTH-1:0] o_y
);
  logic [ADDR_WIDTH-1:0] w_last;

  assign w_last = i_size - ADDR_WIDTH'(1);

  always_comb begin
    o_x = i_x;
    o_y = i_y + ADDR_WIDTH'(1);
    if (i_y >= w_last) begin
      o_y = '0;
      o_x = (i_x < w_last) ? i_x + ADDR_WIDTH'(1) : '0;
    end
  end
endmodule

// File: rtl/output_tile_scheduler.sv
// Walks the S x S output map in batches of ROUTER_COUNT coordinates and issues them to the row routers.
// Define OTS_PERF_CNT_EN to add the o_stall_cycles counter port.
module output_tile_scheduler
  import router_pkg::*;
#(
  parameter int ROUTER_COUNT = OTS_ROUTER_COUNT,
  parameter int ADDR_WIDTH   = OTS_ADDR_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_nrst,
  input  logic                  i_reg_clear,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_o_size,
  output_tile_scheduler_if.master bus,
  output logic                  o_busy,
  output logic                  o_done
`ifdef OTS_PERF_CNT_EN
  ,
  output logic [31:0]           o_stall_cycles
`endif
);
  localparam int REM_W = 2 * ADDR_WIDTH;

  ots_state_t                              r_state;
  logic [ADDR_WIDTH-1:0]                   r_size;
  logic [REM_W-1:0]                        r_rem;
  logic [ADDR_WIDTH-1:0]                   r_base_x, r_base_y;
  logic [ROUTER_COUNT-1:0][ADDR_WIDTH-1:0] r_x, r_y;
  logic [ROUTER_COUNT-1:0]                 r_lane_valid;
  logic                                    r_batch_valid;

  logic [ADDR_WIDTH-1:0]   w_seed_x, w_seed_y, w_seed_size;
  logic [REM_W-1:0]        w_seed_rem, w_sq, w_take;
  logic [ADDR_WIDTH-1:0]   w_lane_x [ROUTER_COUNT];
  logic [ADDR_WIDTH-1:0]   w_lane_y [ROUTER_COUNT];
  logic [ROUTER_COUNT-1:0] w_mask;
  logic [ADDR_WIDTH-1:0]   w_next_x, w_next_y;
  logic                    w_handshake;

  // In IDLE the chain is seeded from the incoming start request so the first batch is ready one cycle later.
  assign w_sq        = REM_W'(i_o_size) * REM_W'(i_o_size);
  assign w_seed_x    = (r_state == IDLE) ? '0       : r_base_x;
  assign w_seed_y    = (r_state == IDLE) ? '0       : r_base_y;
  assign w_seed_size = (r_state == IDLE) ? i_o_size : r_size;
  assign w_seed_rem  = (r_state == IDLE) ? w_sq     : r_rem;
  assign w_take      = (r_rem > REM_W'(ROUTER_COUNT)) ? REM_W'(ROUTER_COUNT) : r_rem;
  assign w_handshake = r_batch_valid & bus.i_batch_ready;

  assign w_lane_x[0] = w_seed_x;
  assign w_lane_y[0] = w_seed_y;

  for (genvar k = 1; k < ROUTER_COUNT; k++) begin : g_lane
    coord_stepper #(.ADDR_WIDTH(ADDR_WIDTH)) u_step (
      .i_x(w_lane_x[k-1]), .i_y(w_lane_y[k-1]), .i_size(w_seed_size),
      .o_x(w_lane_x[k]),   .o_y(w_lane_y[k])
    );
  end

  for (genvar k = 0; k < ROUTER_COUNT; k++) begin : g_mask
    assign w_mask[k] = (w_seed_rem > REM_W'(k));
  end

  // Next batch starts one step past the last lane of the batch currently presented.
  coord_stepper #(.ADDR_WIDTH(ADDR_WIDTH)) u_next_base (
    .i_x(r_x[ROUTER_COUNT-1]), .i_y(r_y[ROUTER_COUNT-1]), .i_size(r_size),
    .o_x(w_next_x),            .o_y(w_next_y)
  );

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_state <= IDLE; r_size <= '0; r_rem <= '0; r_base_x <= '0; r_base_y <= '0;
      r_x <= '0; r_y <= '0; r_lane_valid <= '0; r_batch_valid <= 1'b0; o_busy <= 1'b0; o_done <= 1'b0;
    end else if (i_reg_clear) begin
      r_state <= IDLE; r_size <= '0; r_rem <= '0; r_base_x <= '0; r_base_y <= '0;
      r_x <= '0; r_y <= '0; r_lane_valid <= '0; r_batch_valid <= 1'b0; o_busy <= 1'b0; o_done <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          o_done <= 1'b0;
          if (i_start) begin
            r_size   <= i_o_size;
            r_rem    <= w_sq;
            r_base_x <= '0;
            r_base_y <= '0;
            o_busy   <= 1'b1;
            if (i_o_size == '0) begin
              r_state <= FINISH;
            end else begin
              r_state       <= ISSUE;
              r_batch_valid <= 1'b1;
              r_lane_valid  <= w_mask;
              for (int k = 0; k < ROUTER_COUNT; k++) begin
                r_x[k] <= w_lane_x[k];
                r_y[k] <= w_lane_y[k];
              end
            end
          end
        end
        ISSUE: begin
          if (w_handshake) begin
            r_rem         <= r_rem - w_take;
            r_base_x      <= w_next_x;
            r_base_y      <= w_next_y;
            r_batch_valid <= 1'b0;
            r_state       <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (bus.i_batch_done) begin
            if (r_rem == '0) begin
              r_state <= FINISH;
            end else begin
              r_state       <= ISSUE;
              r_batch_valid <= 1'b1;
              r_lane_valid  <= w_mask;
              for (int k = 0; k < ROUTER_COUNT; k++) begin
                r_x[k] <= w_lane_x[k];
                r_y[k] <= w_lane_y[k];
              end
            end
          end
        end
        FINISH: begin
          o_done  <= 1'b1;
          o_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.o_x           = r_x;
  assign bus.o_y           = r_y;
  assign bus.o_lane_valid  = r_lane_valid;
  assign bus.o_batch_valid = r_batch_valid;

`ifdef OTS_PERF_CNT_EN
  logic w_stall;

  assign w_stall = (r_batch_valid & ~bus.i_batch_ready) | ((r_state == WAIT_DONE) & ~bus.i_batch_done);

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      o_stall_cycles <= '0;
    end else if (i_reg_clear || (r_state == IDLE && i_start)) begin
      o_stall_cycles <= '0;
    end else if (w_stall && o_stall_cycles != 32'hFFFF_FFFF) begin
      o_stall_cycles <= o_stall_cycles + 32'd1;
    end
  end
`endif
endmodule
